// File: rtl/alarm_trigger_if.sv
// Signal bundle between the timekeeping/settings/button logic and
// alarm_trigger. The master side supplies time, alarm settings and button
// pulses; the slave side (alarm_trigger) returns the tone request and the
// status flags.
interface alarm_trigger_if #(
    parameter int CNT_W = 2
);
    logic             sec_tick;
    logic [4:0]       cur_hours;
    logic [5:0]       cur_minutes;
    logic [5:0]       cur_seconds;
    logic [4:0]       alarm_hours;
    logic [5:0]       alarm_minutes;
    logic             alarm_en;
    logic             snooze;
    logic             dismiss;
    logic             ring_on;
    logic             ringing;
    logic             snoozing;
    logic [CNT_W-1:0] snooze_count;

    modport master (
        output sec_tick, cur_hours, cur_minutes, cur_seconds,
               alarm_hours, alarm_minutes, alarm_en, snooze, dismiss,
        input  ring_on, ringing, snoozing, snooze_count
    );

    modport slave (
        input  sec_tick, cur_hours, cur_minutes, cur_seconds,
               alarm_hours, alarm_minutes, alarm_en, snooze, dismiss,
        output ring_on, ringing, snoozing, snooze_count
    );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm sequencer: detects the alarm minute, runs ringing / snooze /
// dismiss, and issues single-cycle ring_on pulses to the tone generator,
// re-issued every RETRIGGER_SEC seconds while ringing.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the rising edge of the alarm-time match
// S_RINGING | alarm sounding; ring_on re-pulsed periodically, auto timeout
// S_SNOOZE  | silenced; counts snooze_sec down, then back to ringing
module alarm_trigger #(
    parameter int RETRIGGER_SEC = 6,
    parameter int SNOOZE_MIN    = 5,
    parameter int MAX_RING_SEC  = 60,
    parameter int MAX_SNOOZES   = 3
) (
    input  logic            clk,
    input  logic            reset,
    alarm_trigger_if.slave  bus
);

    localparam int RING_W   = $clog2(MAX_RING_SEC + 1);
    localparam int RETRIG_W = $clog2(RETRIGGER_SEC + 1);
    localparam int SNOOZE_W = $clog2(SNOOZE_MIN * 60 + 1);
    localparam int CNT_W    = $clog2(MAX_SNOOZES + 1);

    localparam logic [RING_W-1:0]   RING_MAX    = RING_W'(MAX_RING_SEC);
    localparam logic [RING_W-1:0]   RING_ONE    = RING_W'(1);
    localparam logic [RETRIG_W-1:0] RETRIG_MAX  = RETRIG_W'(RETRIGGER_SEC);
    localparam logic [RETRIG_W-1:0] RETRIG_ONE  = RETRIG_W'(1);
    localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_MIN * 60);
    localparam logic [SNOOZE_W-1:0] SNOOZE_ONE  = SNOOZE_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(MAX_SNOOZES);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                match_q, match_d;
    logic [RING_W-1:0]   ring_sec_q, ring_sec_d;
    logic [RETRIG_W-1:0] retrig_sec_q, retrig_sec_d;
    logic [SNOOZE_W-1:0] snooze_sec_q, snooze_sec_d;
    logic [CNT_W-1:0]    snooze_count_q, snooze_count_d;
    logic                ring_on_q, ring_on_d;
    logic                ringing_q, ringing_d;
    logic                snoozing_q, snoozing_d;

    logic                match;
    logic                trigger;
    logic                cancel;
    logic [RING_W-1:0]   ring_sec_inc;
    logic [RETRIG_W-1:0] retrig_sec_inc;

    // Alarm-time compare and its rising edge; match_q resets high so a reset
    // inside the matching second cannot fire the alarm.
    always_comb begin
        match = (bus.cur_hours == bus.alarm_hours) &&
                (bus.cur_minutes == bus.alarm_minutes) &&
                (bus.cur_seconds == 6'd0);
        match_d        = match;
        trigger        = bus.alarm_en && match && !match_q;
        cancel         = bus.dismiss || !bus.alarm_en;
        ring_sec_inc   = ring_sec_q + RING_ONE;
        retrig_sec_inc = retrig_sec_q + RETRIG_ONE;
    end

    // Next-state and timer logic; button actions take precedence over a
    // coincident sec_tick, and an ignored snooze lets the tick count.
    always_comb begin
        state_d        = state_q;
        ring_sec_d     = ring_sec_q;
        retrig_sec_d   = retrig_sec_q;
        snooze_sec_d   = snooze_sec_q;
        snooze_count_d = snooze_count_q;
        ring_on_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                snooze_count_d = '0;
                if (trigger) begin
                    state_d      = S_RINGING;
                    ring_sec_d   = '0;
                    retrig_sec_d = '0;
                    ring_on_d    = 1'b1;
                end
            end

            S_RINGING: begin
                if (cancel) begin
                    state_d        = S_IDLE;
                    snooze_count_d = '0;
                end else if (bus.snooze && (snooze_count_q < CNT_MAX)) begin
                    state_d        = S_SNOOZE;
                    snooze_count_d = snooze_count_q + CNT_ONE;
                    snooze_sec_d   = SNOOZE_LOAD;
                end else if (bus.sec_tick) begin
                    ring_sec_d   = ring_sec_inc;
                    retrig_sec_d = retrig_sec_inc;
                    if (ring_sec_inc == RING_MAX) begin
                        // Timeout wins over a coincident retrigger.
                        state_d        = S_IDLE;
                        snooze_count_d = '0;
                    end else if (retrig_sec_inc == RETRIG_MAX) begin
                        retrig_sec_d = '0;
                        ring_on_d    = 1'b1;
                    end
                end
            end

            S_SNOOZE: begin
                if (cancel) begin
                    state_d        = S_IDLE;
                    snooze_count_d = '0;
                end else if (bus.sec_tick) begin
                    snooze_sec_d = snooze_sec_q - SNOOZE_ONE;
                    if (snooze_sec_q == SNOOZE_ONE) begin
                        state_d      = S_RINGING;
                        ring_sec_d   = '0;
                        retrig_sec_d = '0;
                        ring_on_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d        = S_IDLE;
                snooze_count_d = '0;
            end
        endcase

        ringing_d  = (state_d == S_RINGING);
        snoozing_d = (state_d == S_SNOOZE);
    end

    // State, timers and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            match_q        <= 1'b1;
            ring_sec_q     <= '0;
            retrig_sec_q   <= '0;
            snooze_sec_q   <= '0;
            snooze_count_q <= '0;
            ring_on_q      <= 1'b0;
            ringing_q      <= 1'b0;
            snoozing_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            match_q        <= match_d;
            ring_sec_q     <= ring_sec_d;
            retrig_sec_q   <= retrig_sec_d;
            snooze_sec_q   <= snooze_sec_d;
            snooze_count_q <= snooze_count_d;
            ring_on_q      <= ring_on_d;
            ringing_q      <= ringing_d;
            snoozing_q     <= snoozing_d;
        end
    end

    assign bus.ring_on      = ring_on_q;
    assign bus.ringing      = ringing_q;
    assign bus.snoozing     = snoozing_q;
    assign bus.snooze_count = snooze_count_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: expected ring_on pulses are queued by the
// stimulus and consumed by an independent monitor; state flags are checked
// directly after each step.
module tb_alarm_trigger;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        int cyc;
        int ringing;
        int cnt;
    } exp_t;

    exp_t exp_q[$];

    alarm_trigger_if #(.CNT_W(2)) bus();

    alarm_trigger #(
        .RETRIGGER_SEC (6),
        .SNOOZE_MIN    (1),
        .MAX_RING_SEC  (20),
        .MAX_SNOOZES   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ring_on pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.ring_on) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL ring_on: unexpected pulse at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.ringing != int'(bus.ringing) || e.cnt != int'(bus.snooze_count)) begin
                    miscompares++;
                    $display("FAIL ring_on: got cycle %0d ringing %0d count %0d, expected cycle %0d ringing %0d count %0d",
                             cyc, bus.ringing, bus.snooze_count, e.cyc, e.ringing, e.cnt);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input int ringing, input int cnt);
        exp_t e;
        e.cyc = cyc + 1;
        e.ringing = ringing;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.cur_hours   = 5'(h);
        bus.cur_minutes = 6'(m);
        bus.cur_seconds = 6'(s);
    endtask

    task automatic advance_time();
        if (bus.cur_seconds == 6'd59) begin
            bus.cur_seconds = 6'd0;
            if (bus.cur_minutes == 6'd59) begin
                bus.cur_minutes = 6'd0;
                bus.cur_hours = (bus.cur_hours == 5'd23) ? 5'd0 : bus.cur_hours + 5'd1;
            end else begin
                bus.cur_minutes = bus.cur_minutes + 6'd1;
            end
        end else begin
            bus.cur_seconds = bus.cur_seconds + 6'd1;
        end
    endtask

    // One second tick (with time advancing); optionally expect a pulse.
    task automatic do_tick(input bit pulse, input int cnt);
        bus.sec_tick = 1'b1;
        advance_time();
        if (pulse) expect_pulse(1, cnt);
        step();
        bus.sec_tick = 1'b0;
        step();
    endtask

    task automatic press(input bit sn, input bit dm, input bit tk);
        bus.snooze   = sn;
        bus.dismiss  = dm;
        bus.sec_tick = tk;
        step();
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        bus.sec_tick = 1'b0;
        step();
    endtask

    // Approach 07:30:00 from 07:29:59 and expect the trigger pulse.
    task automatic fire_alarm();
        set_time(7, 29, 59);
        step();
        step();
        set_time(7, 30, 0);
        expect_pulse(1, 0);
        step();
        chk("fire ringing", int'(bus.ringing), 1);
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.sec_tick = 1'b0;
        bus.snooze = 1'b0;
        bus.dismiss = 1'b0;
        bus.alarm_en = 1'b1;
        bus.alarm_hours = 5'd7;
        bus.alarm_minutes = 6'd30;
        set_time(7, 29, 59);
        repeat (3) step();
        chk("reset ring_on", int'(bus.ring_on), 0);
        chk("reset ringing", int'(bus.ringing), 0);
        chk("reset snoozing", int'(bus.snoozing), 0);
        chk("reset count", int'(bus.snooze_count), 0);
        reset = 1'b0;
        step();

        // Trigger once, then hold the matching second with no retrigger.
        set_time(7, 30, 0);
        expect_pulse(1, 0);
        step();
        chk("trigger ringing", int'(bus.ringing), 1);
        chk("trigger count", int'(bus.snooze_count), 0);
        repeat (1000) step();
        chk("hold ringing", int'(bus.ringing), 1);

        // Unattended ring: pulses on ticks 6, 12, 18; timeout on tick 20.
        for (int t = 1; t <= 19; t++) do_tick((t % 6) == 0, 0);
        chk("pre-timeout ringing", int'(bus.ringing), 1);
        do_tick(1'b0, 0);
        chk("timeout ringing", int'(bus.ringing), 0);
        chk("timeout snoozing", int'(bus.snoozing), 0);
        for (int t = 0; t < 8; t++) do_tick(1'b0, 0);

        // Snooze after 3 s, resume after 60 ticks.
        fire_alarm();
        for (int t = 0; t < 3; t++) do_tick(1'b0, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("snooze1 snoozing", int'(bus.snoozing), 1);
        chk("snooze1 ringing", int'(bus.ringing), 0);
        chk("snooze1 count", int'(bus.snooze_count), 1);
        for (int t = 1; t <= 59; t++) do_tick(1'b0, 1);
        chk("snooze1 tick59", int'(bus.snoozing), 1);
        do_tick(1'b1, 1);
        chk("resume1 ringing", int'(bus.ringing), 1);
        chk("resume1 snoozing", int'(bus.snoozing), 0);

        // Second and third snoozes, fourth one ignored.
        press(1'b1, 1'b0, 1'b0);
        chk("snooze2 count", int'(bus.snooze_count), 2);
        for (int t = 1; t <= 60; t++) do_tick(t == 60, 2);
        press(1'b1, 1'b0, 1'b0);
        chk("snooze3 count", int'(bus.snooze_count), 3);
        chk("snooze3 snoozing", int'(bus.snoozing), 1);
        for (int t = 1; t <= 60; t++) do_tick(t == 60, 3);
        press(1'b1, 1'b0, 1'b0);
        chk("snooze4 ringing", int'(bus.ringing), 1);
        chk("snooze4 snoozing", int'(bus.snoozing), 0);
        chk("snooze4 count", int'(bus.snooze_count), 3);
        for (int t = 1; t <= 7; t++) do_tick(t == 6, 3);
        press(1'b0, 1'b1, 1'b0);
        chk("dismiss ringing", int'(bus.ringing), 0);
        chk("dismiss count", int'(bus.snooze_count), 0);
        press(1'b1, 1'b0, 1'b0);
        chk("idle snooze ignored", int'(bus.snoozing), 0);

        // Dismiss coincident with a tick while snoozing.
        fire_alarm();
        press(1'b1, 1'b0, 1'b0);
        chk("snooze before dismiss", int'(bus.snoozing), 1);
        press(1'b0, 1'b1, 1'b1);
        chk("dismiss+tick snoozing", int'(bus.snoozing), 0);
        chk("dismiss+tick ringing", int'(bus.ringing), 0);
        chk("dismiss+tick count", int'(bus.snooze_count), 0);

        // Disarm mid-ring.
        fire_alarm();
        do_tick(1'b0, 0);
        do_tick(1'b0, 0);
        bus.alarm_en = 1'b0;
        step();
        chk("disarm ringing", int'(bus.ringing), 0);
        for (int t = 0; t < 8; t++) do_tick(1'b0, 0);
        bus.alarm_en = 1'b1;

        // Reset inside the matching second must not refire.
        fire_alarm();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("post-reset ringing", int'(bus.ringing), 0);
        chk("post-reset snoozing", int'(bus.snoozing), 0);
        chk("post-reset count", int'(bus.snooze_count), 0);
        chk("post-reset ring_on", int'(bus.ring_on), 0);

        // Next day's edge fires normally.
        fire_alarm();
        press(1'b0, 1'b1, 1'b0);
        chk("final dismiss", int'(bus.ringing), 0);

        repeat (20) step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
